key_sw_debounce: RTL and testbench

//  Input conditioner placed directly upstream of the 3-second hold/invert stage.

---
 rtl/key_sw_debounce_if.sv | 23 ++
 rtl/key_sw_debounce.sv | 132 +++++++++++++
 tb/tb_key_sw_debounce.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/key_sw_debounce_if.sv
// Raw button/switch inputs and debounced outputs of the input conditioner.
// The conditioner takes the slave side; the stimulus or upstream pin logic takes the master side.
interface key_sw_debounce_if #(
  parameter int DATA_W = 4
);
  logic              key_raw;
  logic [DATA_W-1:0] sw_raw;
  logic              en_key;
  logic              key_press;
  logic              key_release;
  logic [DATA_W-1:0] data;
  logic              data_valid;

  modport master (
    output key_raw, sw_raw,
    input  en_key, key_press, key_release, data, data_valid
  );

  modport slave (
    input  key_raw, sw_raw,
    output en_key, key_press, key_release, data, data_valid
  );
endinterface

// File: rtl/key_sw_debounce.sv
// Synchronises and debounces one push-button and a switch bank ahead of the hold/invert stage.
// Emits a clean key level, a stable data word and single-cycle press/release/data-change pulses.
module key_sw_debounce #(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DATA_W         = 4
) (
  input logic           FPGA_CLK,
  input logic           FPGA_RST,
  key_sw_debounce_if.slave bus
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic           KEY_IDLE = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [1:0]        key_sync;
  logic [DATA_W-1:0] sw_meta;
  logic [DATA_W-1:0] sw_sync;
  logic              k;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              en_key_q;
  logic              press_q;
  logic              release_q;

  logic [DATA_W-1:0] last;
  logic [CNT_W-1:0]  scnt;
  logic [DATA_W-1:0] data_q;
  logic              data_valid_q;

  // The key chain resets to the released pin level so no phantom press follows reset.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      key_sync <= {2{KEY_IDLE}};
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_sync <= {key_sync[0], bus.key_raw};
      sw_meta  <= bus.sw_raw;
      sw_sync  <= sw_meta;
    end
  end

  assign k = key_sync[1] ^ KEY_ACTIVE_LOW;

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      state     <= IDLE;
      cnt       <= '0;
      en_key_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state)
        IDLE: begin
          if (k) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!k) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state    <= PRESSED;
            en_key_q <= 1'b1;
            press_q  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!k) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (k) begin
            state <= PRESSED;
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE;
            en_key_q  <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // scnt saturates once the word is stable; a new data pulse needs the word to differ from data.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      last         <= '0;
      scnt         <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      last         <= sw_sync;
      if (sw_sync != last) begin
        scnt <= '0;
      end else if (scnt < CNT_MAX) begin
        scnt <= scnt + CNT_W'(1);
      end else if (sw_sync != data_q) begin
        data_q       <= sw_sync;
        data_valid_q <= 1'b1;
      end
    end
  end

  assign bus.en_key      = en_key_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.data        = data_q;
  assign bus.data_valid  = data_valid_q;

endmodule

// File: tb/tb_key_sw_debounce.sv
// Directed bench for key_sw_debounce (DEBOUNCE_CYC=8, active-low key).
// Expected pulses are queued with their edge number; a monitor pops and compares each pulse.
module tb_key_sw_debounce;

  localparam int KIND_PRESS   = 0;
  localparam int KIND_RELEASE = 1;
  localparam int KIND_DATA    = 2;
  localparam int LAT          = 11;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   vectors;
  int   miscompares;
  ev_t  exp_q[$];

  key_sw_debounce_if #(.DATA_W(4)) bus ();

  key_sw_debounce #(
    .DEBOUNCE_CYC  (8),
    .KEY_ACTIVE_LOW(1'b1),
    .DATA_W        (4)
  ) dut (
    .FPGA_CLK(clk),
    .FPGA_RST(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic key, input logic [3:0] sw);
    bus.key_raw = key;
    bus.sw_raw  = sw;
  endtask

  // Inputs change at a negedge, so the next posedge is edge 0 and the pulse lands LAT counts later.
  task automatic expect_event(input int kind, input logic [3:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = edge_cnt + LAT;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] req);
    vectors = vectors + 1;
    if (got !== req) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic pop_and_compare(input int kind);
    ev_t e;
    vectors = vectors + 1;
    if (exp_q.size() == 0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL unexpected_pulse: got kind=%0d at edge %0d, required no pulse", kind, edge_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != edge_cnt ||
          (kind == KIND_DATA && e.data !== bus.data) ||
          (kind == KIND_PRESS && bus.en_key !== 1'b1) ||
          (kind == KIND_RELEASE && bus.en_key !== 1'b0)) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL pulse_event: got kind=%0d edge=%0d data=%h en_key=%b, required kind=%0d edge=%0d data=%h",
                 kind, edge_cnt, bus.data, bus.en_key, e.kind, e.cyc, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.key_press === 1'b1)   pop_and_compare(KIND_PRESS);
      if (bus.key_release === 1'b1) pop_and_compare(KIND_RELEASE);
      if (bus.data_valid === 1'b1)  pop_and_compare(KIND_DATA);
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    apply_stimulus(1'b0, 4'hF);

    for (int i = 0; i < 3; i++) begin
      wait_cycles(1);
      check_output("reset_outputs",
                   {1'b0, bus.en_key, bus.key_press, bus.key_release, bus.data_valid, bus.data[2:0]} |
                   {7'd0, bus.data[3]}, 8'h00);
    end
    rst = 1'b0;
    apply_stimulus(1'b1, 4'h0);
    wait_cycles(1);
    check_output("post_reset_outputs",
                 {3'b000, bus.en_key, bus.key_press, bus.key_release, bus.data_valid, 1'b0} | {4'h0, bus.data},
                 8'h00);

    $display("[TB] key bounce");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 4'h0);
      wait_cycles(5);
      apply_stimulus(1'b1, 4'h0);
      wait_cycles(2);
    end
    wait_cycles(12);
    check_output("bounce_en_key", {7'd0, bus.en_key}, 8'h00);

    $display("[TB] clean press and release");
    apply_stimulus(1'b0, 4'h0);
    expect_event(KIND_PRESS, 4'h0);
    wait_cycles(30);
    check_output("held_en_key", {7'd0, bus.en_key}, 8'h01);
    apply_stimulus(1'b1, 4'h0);
    expect_event(KIND_RELEASE, 4'h0);
    wait_cycles(20);
    check_output("released_en_key", {7'd0, bus.en_key}, 8'h00);

    $display("[TB] release glitch");
    apply_stimulus(1'b0, 4'h0);
    expect_event(KIND_PRESS, 4'h0);
    wait_cycles(15);
    apply_stimulus(1'b1, 4'h0);
    wait_cycles(3);
    apply_stimulus(1'b0, 4'h0);
    wait_cycles(15);
    check_output("glitch_en_key", {7'd0, bus.en_key}, 8'h01);
    apply_stimulus(1'b1, 4'h0);
    expect_event(KIND_RELEASE, 4'h0);
    wait_cycles(15);

    $display("[TB] switches");
    apply_stimulus(1'b1, 4'hA);
    expect_event(KIND_DATA, 4'hA);
    wait_cycles(15);
    check_output("data_A", {4'h0, bus.data}, 8'h0A);
    apply_stimulus(1'b1, 4'h5);
    wait_cycles(4);
    apply_stimulus(1'b1, 4'hA);
    wait_cycles(20);
    check_output("data_hold_A", {4'h0, bus.data}, 8'h0A);

    $display("[TB] reset mid-debounce");
    apply_stimulus(1'b0, 4'hA);
    wait_cycles(8);
    rst = 1'b1;
    wait_cycles(1);
    check_output("mid_reset_en_key", {7'd0, bus.en_key}, 8'h00);
    check_output("mid_reset_data", {4'h0, bus.data}, 8'h00);
    rst = 1'b0;
    apply_stimulus(1'b0, 4'h0);
    expect_event(KIND_PRESS, 4'h0);
    wait_cycles(5);
    check_output("redebounce_en_key_low", {7'd0, bus.en_key}, 8'h00);
    wait_cycles(10);
    check_output("redebounce_en_key_high", {7'd0, bus.en_key}, 8'h01);

    wait_cycles(5);
    check_output("pending_events", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
